// File: rtl/repeated_sub_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider: default width,
// FSM state encoding and the quotient reported on a zero divisor.
package repeated_sub_divider_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SUB  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = {WIDTH_DEFAULT{1'b1}};

endpackage

// File: rtl/repeated_sub_divider_sub_unit4.sv
// Combinational WIDTH-bit subtractor; borrow_out_o doubles as the a<b compare.
module sub_unit4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
);

  logic [WIDTH:0] wide_diff_s;

  // One extra bit captures the borrow of the modulo-2^WIDTH difference
  assign wide_diff_s  = {1'b0, a_i} - {1'b0, b_i};
  assign diff_o       = wide_diff_s[WIDTH-1:0];
  assign borrow_out_o = wide_diff_s[WIDTH];

endmodule

// File: rtl/repeated_sub_divider.sv
// Sequential unsigned divider: subtracts the captured divisor once per clock
// until the working remainder drops below it, counting subtractions as quotient.
module repeated_sub_divider
  import repeated_sub_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;
  logic             div_zero_s;

  sub_unit4 #(.WIDTH(WIDTH)) u_sub (
    .a_i          (rem_q),
    .b_i          (div_q),
    .diff_o       (diff_s),
    .borrow_out_o (borrow_s)
  );

  assign div_zero_s = (divisor == ZERO);

  // State and datapath registers; reset clears any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= ZERO;
      div_q   <= ZERO;
      quo_q   <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = div_zero_s ? ST_DONE : ST_SUB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB: begin
        if (borrow_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SUB;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output-register updates; a borrow means rem_q < div_q
  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d  = dividend;
          div_d  = divisor;
          quo_d  = div_zero_s ? ALL_ONE : ZERO;
          dbz_d  = div_zero_s;
          busy_d = !div_zero_s;
          done_d = div_zero_s;
        end else begin
          done_d = 1'b0;
        end
      end
      ST_SUB: begin
        if (!borrow_s) begin
          rem_d = diff_s;
          quo_d = quo_q + ONE;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_DONE: done_d = 1'b0;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;

endmodule
